// File: rtl/adc_i2s_receiver.sv
// adc_i2s_receiver: deserialises the codec I2S ADC stream into left/right pairs held in a show-ahead FIFO.
// Latency: sampling pulse 3 CLOCK_50 cycles after an AUD_BCLK rise; pair visible 1 cycle after the closing LRCK pulse.
// Backpressure: none toward the codec; a pair completing into a full FIFO with no pop is dropped and sets overflow.
// Optional build macro ADC_RX_OVF_COUNT_EN adds a saturating 16-bit dropped-pair counter (overflow_count).

module adc_i2s_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign do_pop   = pop_rdy && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module adc_i2s_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  clear_audio_in_memory,
  input  logic                  read_audio_in,
  output logic                  audio_in_available,
  output logic [DATA_WIDTH-1:0] left_channel_audio_in,
  output logic [DATA_WIDTH-1:0] right_channel_audio_in,
`ifdef ADC_RX_OVF_COUNT_EN
  output logic [15:0]           overflow_count,
`endif
  output logic                  overflow
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BIT_MAX = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_ALIGN, ST_DELAY, ST_SHIFT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    bclk_s1, bclk_s2, bclk_s3;
  logic                    lrck_s1, lrck_s2, lrck_prev;
  logic                    dat_s1, dat_s2;
  logic                    bit_pulse;
  logic                    lrck_chg;
  logic                    start_half;
  logic                    shift_en;
  logic                    latch_left;
  logic                    push_pair;
  logic                    pair_drop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   left_reg;
  logic [2*DATA_WIDTH-1:0] head_dat;

  // Two-flop synchronisers for the codec pins plus a third BCLK flop for edge detection.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      {bclk_s1, bclk_s2, bclk_s3} <= 3'b000;
      {lrck_s1, lrck_s2}          <= 2'b00;
      {dat_s1, dat_s2}            <= 2'b00;
    end else begin
      {bclk_s1, bclk_s2, bclk_s3} <= {AUD_BCLK, bclk_s1, bclk_s2};
      {lrck_s1, lrck_s2}          <= {AUD_ADCLRCK, lrck_s1};
      {dat_s1, dat_s2}            <= {AUD_ADCDAT, dat_s1};
    end
  end

  assign bit_pulse = bclk_s2 && !bclk_s3;
  assign lrck_chg  = bit_pulse && (lrck_s2 != lrck_prev);

  // LRCK as seen at the previous bit; also names the channel a change is closing (0 = left).
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)        lrck_prev <= 1'b0;
    else if (bit_pulse) lrck_prev <= lrck_s2;
  end

  // Framing state register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_ALIGN;
    else         state <= state_nxt;
  end

  // Framing next-state and datapath strobes; flush forces realignment.
  always_comb begin
    state_nxt  = state;
    start_half = 1'b0;
    shift_en   = 1'b0;
    latch_left = 1'b0;
    push_pair  = 1'b0;
    case (state)
      ST_ALIGN: if (lrck_chg && !lrck_s2) state_nxt = ST_DELAY;
      ST_DELAY: begin
        if (lrck_chg) begin
          state_nxt = ST_ALIGN;
        end else if (bit_pulse) begin
          state_nxt  = ST_SHIFT;
          start_half = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (lrck_chg) begin
          state_nxt = ST_DELAY;
          if (lrck_prev) push_pair  = 1'b1;
          else           latch_left = 1'b1;
        end else if (bit_pulse && (bit_cnt < BIT_MAX)) begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = ST_ALIGN;
    endcase
    if (clear_audio_in_memory) state_nxt = ST_ALIGN;
  end

  // MSB-first capture into a left-justified register; bits past DATA_WIDTH fall away.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      left_reg  <= '0;
    end else if (clear_audio_in_memory) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (start_half) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= shift_reg | ({DATA_WIDTH{dat_s2}} & (MSB_ONE >> bit_cnt));
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (latch_left) left_reg <= shift_reg;
    end
  end

  adc_i2s_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .clr      (clear_audio_in_memory),
    .push_vld (push_pair),
    .push_dat ({left_reg, shift_reg}),
    .pop_rdy  (read_audio_in),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  assign audio_in_available     = !fifo_empty;
  assign left_channel_audio_in  = head_dat[2*DATA_WIDTH-1:DATA_WIDTH];
  assign right_channel_audio_in = head_dat[DATA_WIDTH-1:0];
  // When full, any read is a real pop, so the pair is lost only without one.
  assign pair_drop              = push_pair && fifo_full && !read_audio_in;

  // Sticky overflow flag.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                    overflow <= 1'b0;
    else if (clear_audio_in_memory) overflow <= 1'b0;
    else if (pair_drop)             overflow <= 1'b1;
  end

`ifdef ADC_RX_OVF_COUNT_EN
  // Saturating dropped-pair counter.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                                  overflow_count <= '0;
    else if (clear_audio_in_memory)               overflow_count <= '0;
    else if (pair_drop && overflow_count != '1)   overflow_count <= overflow_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_adc_i2s_receiver.sv
// tb_adc_i2s_receiver: random I2S frames against a queue-based pair model; a monitor checks every pop.
// Latency: bit timing is 4 CLOCK_50 cycles per BCLK phase; pushes land 3 cycles after the closing rise.
// Backpressure: reads are issued in drain bursts and one exactly-timed pop aligned with a push.

module tb_adc_i2s_receiver;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic CLOCK_50 = 1'b0;
  logic resetn = 1'b0;
  logic AUD_BCLK = 1'b0;
  logic AUD_ADCLRCK = 1'b0;
  logic AUD_ADCDAT = 1'b0;
  logic clear_audio_in_memory = 1'b0;
  logic read_audio_in = 1'b0;
  logic audio_in_available;
  logic overflow;
  logic [DW-1:0] left_channel_audio_in;
  logic [DW-1:0] right_channel_audio_in;
`ifdef ADC_RX_OVF_COUNT_EN
  logic [15:0] overflow_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents as {left,right}, plus framing bookkeeping.
  logic [2*DW-1:0] exp_q[$];
  logic            exp_ovf = 1'b0;
  int              exp_cnt = 0;
  bit              aligned = 1'b0;
  bit              got_r = 1'b0;
  logic [DW-1:0]   cur_l = '0;
  logic [DW-1:0]   cur_r = '0;
  logic            last_lr = 1'b0;

  adc_i2s_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50               (CLOCK_50),
    .resetn                 (resetn),
    .AUD_BCLK               (AUD_BCLK),
    .AUD_ADCLRCK            (AUD_ADCLRCK),
    .AUD_ADCDAT             (AUD_ADCDAT),
    .clear_audio_in_memory  (clear_audio_in_memory),
    .read_audio_in          (read_audio_in),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
`ifdef ADC_RX_OVF_COUNT_EN
    .overflow_count         (overflow_count),
`endif
    .overflow               (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample value as the receiver should present it: first DW bits sent, left-justified.
  function automatic logic [DW-1:0] justify(input logic [63:0] v, input int n);
    logic [63:0] m;
    if (n > DW) return DW'(v >> (n - DW));
    m = (64'd1 << n) - 64'd1;
    return DW'((v & m) << (DW - n));
  endfunction

  function automatic void model_push(input logic [2*DW-1:0] p, input bit conc_pop);
    if (exp_q.size() < DEPTH || conc_pop) begin
      exp_q.push_back(p);
    end else begin
      exp_ovf = 1'b1;
      if (exp_cnt < 65535) exp_cnt++;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_cnt = 0;
    aligned = 1'b0;
    got_r   = 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // One BCLK period; mode 1 pops, mode 3 flushes, in the cycle the rise is sampled; mode 2 checks push latency.
  task automatic send_bit(input logic lr, input logic b, input int mode);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = b;
    tick(4);
    AUD_BCLK = 1'b1;
    case (mode)
      1: begin
        tick(2); read_audio_in = 1'b1;
        tick(1); read_audio_in = 1'b0;
        tick(1);
      end
      2: begin
        tick(2); check("avail_before_push", audio_in_available, 0);
        tick(1); check("avail_after_push", audio_in_available, 1);
        tick(1);
      end
      3: begin
        tick(2); clear_audio_in_memory = 1'b1;
        tick(1); clear_audio_in_memory = 1'b0;
        check("clear_avail", audio_in_available, 0);
        check("clear_overflow", overflow, 0);
`ifdef ADC_RX_OVF_COUNT_EN
        check("clear_ovf_count", overflow_count, 0);
`endif
        tick(1);
      end
      default: tick(4);
    endcase
  endtask

  // Half-frame: change bit, delay bit, then nbits of val MSB-first.
  task automatic send_half(input logic lr, input logic [63:0] val, input int nbits, input int mode);
    if (mode == 3) begin
      model_clear();
    end else if (lr == 1'b0 && last_lr == 1'b1) begin
      if (aligned && got_r) model_push({cur_l, cur_r}, mode == 1);
      aligned = 1'b1;
      got_r   = 1'b0;
      cur_l   = justify(val, nbits);
    end else if (lr == 1'b1 && last_lr == 1'b0 && aligned) begin
      got_r = 1'b1;
      cur_r = justify(val, nbits);
    end
    last_lr = lr;
    send_bit(lr, 1'($urandom), mode);
    send_bit(lr, 1'($urandom), 0);
    for (int i = nbits - 1; i >= 0; i--) send_bit(lr, val[i], 0);
  endtask

  task automatic send_rand_half(input logic lr, input int mode);
    send_half(lr, {$urandom, $urandom}, int'($urandom_range(1, 40)), mode);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && audio_in_available; i++) begin
      read_audio_in = 1'b1;
      tick(1);
    end
    read_audio_in = 1'b0;
    tick(1);
    check("drain_model_left", exp_q.size(), 0);
    check("drain_avail", audio_in_available, 0);
    check("empty_left_zero", left_channel_audio_in, 0);
    check("empty_right_zero", right_channel_audio_in, 0);
  endtask

  task automatic check_ovf(input string name);
    check(name, overflow, exp_ovf);
`ifdef ADC_RX_OVF_COUNT_EN
    check({name, "_count"}, overflow_count, 64'(exp_cnt));
`endif
  endtask

  // Monitor: every DUT pop is compared against the oldest modelled pair.
  always @(negedge CLOCK_50) begin
    logic [2*DW-1:0] e;
    if (resetn && read_audio_in && audio_in_available) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got %h/%h expected no data", left_channel_audio_in, right_channel_audio_in);
      end else begin
        e = exp_q.pop_front();
        check("pop_left", left_channel_audio_in, e[2*DW-1:DW]);
        check("pop_right", right_channel_audio_in, e[DW-1:0]);
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    resetn = 1'b1;
    tick(2);
    check("reset_avail", audio_in_available, 0);
    check("reset_left", left_channel_audio_in, 0);
    check("reset_right", right_channel_audio_in, 0);
    check_ovf("reset_overflow");

    // Known frame, then a 24-bit frame; the left start of the second pushes the first.
    send_half(1, 64'h0, 3, 0);
    send_half(0, 64'h8000_0001, 32, 0);
    send_half(1, 64'h7FFF_FFFE, 32, 0);
    send_half(0, 64'hAB_CDEF, 24, 2);
    check("head_left", left_channel_audio_in, 32'h8000_0001);
    check("head_right", right_channel_audio_in, 32'h7FFF_FFFE);
    send_half(1, {$urandom, $urandom}, 24, 0);
    send_half(0, {$urandom, $urandom}, 40, 0);
    drain();

    // Random lengths, including over-long halves.
    for (int f = 0; f < 5; f++) begin
      send_rand_half(1, 0);
      send_rand_half(0, 0);
    end
    drain();

    // Fill to depth, push alongside a pop, then drop one.
    for (int f = 0; f < DEPTH; f++) begin
      send_rand_half(1, 0);
      send_rand_half(0, 0);
    end
    check("full_avail", audio_in_available, 1);
    check_ovf("full_no_overflow");
    send_rand_half(1, 0);
    send_rand_half(0, 1);
    check_ovf("push_pop_full_overflow");
    send_rand_half(1, 0);
    send_rand_half(0, 0);
    check_ovf("drop_overflow");
    drain();
    check_ovf("overflow_sticky");

    // Flush coinciding with a push.
    send_rand_half(1, 0);
    send_rand_half(0, 0);
    send_rand_half(1, 0);
    send_rand_half(0, 3);

    // Stream resumes mid-right; only complete frames count.
    send_rand_half(1, 0);
    for (int f = 0; f < 2; f++) begin
      send_rand_half(0, 0);
      send_rand_half(1, 0);
    end
    send_rand_half(0, 0);
    drain();

    // Reset in the middle of a left half.
    AUD_BCLK = 1'b0;
    tick(2);
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    model_clear();
    tick(2);
    check_ovf("midreset_overflow");
    for (int f = 0; f < 2; f++) begin
      send_rand_half(1, 0);
      send_rand_half(0, 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
